// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register-port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_arb_pkg;

    // Arbiter FSM states. LOCKED restricts grants to a single owner.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 3;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_LOCK_MAX = 16;

    // Width of an index into n requesters, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted req at ptr, ptr+1, ... wrapping to 0.
// Latency: combinational.
// Backpressure: none; losers simply see no winner bit this cycle.
//
// Ports: req (request vector), ptr (highest-priority index),
//        onehot/idx (winner as one-hot and as index), any (a winner exists).
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    // Scan from the farthest offset down to ptr itself, so the candidate
    // closest to ptr is the last one written and therefore wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int off = N - 1; off >= 0; off--) begin
            pos = IW'((int'(ptr) + off) % N);
            if (req[pos]) begin
                onehot      = '0;
                onehot[pos] = 1'b1;
                idx         = pos;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_port_arbiter.sv
// Shares one register-file port among NUM_REQ requesters, round-robin, optional lock.
// Latency: grant/rf access same cycle; read data and rvalid one cycle after a read grant.
// Backpressure: losers hold req/we/addr/wdata until gnt; one access per cycle.
//
// Ports: Clk, Reset (async, active-high); per-requester req/we/addr/wdata/lock;
//        gnt, rvalid, rdata back to requesters; rf_en/rf_we/rf_addr/rf_wdata/rf_rdata
//        to the register file; lock_timeout pulses when a stale lock is broken.
// Build option: define ARB_LOCK_EN to compile lock support; otherwise lock is ignored.
module reg_port_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    input  logic [NUM_REQ-1:0]        lock,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rf_en,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [DATA_W-1:0]         rf_rdata,
    output logic                      lock_timeout
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               grant;
    logic               rd_grant;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req    (elig),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Reset blocks issue combinationally so nothing reaches the register file
    // while the arbiter is being cleared.
    assign grant    = win_any & ~Reset;
    assign rd_grant = grant & ~we[win_idx];

    assign gnt      = grant ? win_oh : '0;
    assign rf_en    = grant;
    assign rf_we    = grant & we[win_idx];
    assign rf_addr  = grant ? addr[win_idx*ADDR_W +: ADDR_W]  : '0;
    assign rf_wdata = grant ? wdata[win_idx*DATA_W +: DATA_W] : '0;

`ifdef ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] idle_cnt;

    // While locked only the owner's request is visible to the picker.
    always_comb begin
        elig = req;
        if (state == LOCKED) begin
            elig        = '0;
            elig[owner] = req[owner];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            owner        <= '0;
            idle_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant && lock[win_idx]) begin
                        state    <= LOCKED;
                        owner    <= win_idx;
                        idle_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (grant) begin
                        // Any owner access restarts the stale-lock window.
                        idle_cnt <= '0;
                        if (!lock[win_idx]) begin
                            state <= IDLE;
                        end
                    end else if (!req[owner]) begin
                        if (idle_cnt == CNT_W'(LOCK_MAX - 1)) begin
                            state        <= IDLE;
                            idle_cnt     <= '0;
                            lock_timeout <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    localparam int LOCK_MAX_UNUSED = LOCK_MAX;
    logic [NUM_REQ-1:0] lock_unused;

    assign lock_unused  = lock;
    assign state        = IDLE;
    assign elig         = req;
    assign lock_timeout = 1'b0;
`endif

    // Read data is captured at the grant edge; a write committed on the
    // previous edge is therefore already visible to a following read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr    <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_grant ? win_oh : '0;
            if (rd_grant) begin
                rdata <= rf_rdata;
            end
            // Fairness pointer is frozen during a lock so the pre-lock
            // rotation resumes once the lock is released.
            if (grant && state == IDLE) begin
                ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            end
        end
    end

endmodule
